// File: rtl/hit_readout_pkg.sv
// Shared types and constants for the hit readout sequencer and its frame serializer.
package hit_readout_pkg;

    localparam int         N_CH      = 24;
    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WINDOW,
        ST_SEND,
        ST_CLEAR
    } state_t;

    // Byte idx of a frame: header, snapshot low/mid/high, sequence number.
    function automatic logic [7:0] frame_byte(input logic [2:0]      idx,
                                              input logic [N_CH-1:0] snap,
                                              input logic [7:0]      seq);
        case (idx)
            3'd0:    frame_byte = FRAME_HDR;
            3'd1:    frame_byte = snap[7:0];
            3'd2:    frame_byte = snap[15:8];
            3'd3:    frame_byte = snap[23:16];
            default: frame_byte = seq;
        endcase
    endfunction

endpackage

// File: rtl/hit_frame_serializer.sv
// Streams one 5-byte hit frame over a valid/ready byte port and flags the last transfer.
import hit_readout_pkg::*;

module hit_frame_serializer (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N_CH-1:0] snap,
    input  logic [7:0]      seq,
    input  logic            tx_ready,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    output logic            done
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    logic [2:0] idx;

    // Present the header on start, then advance one byte per accepted transfer.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (start) begin
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= FRAME_HDR;
        end else if (tx_valid && tx_ready) begin
            if (idx == LAST_IDX) begin
                idx      <= '0;
                tx_valid <= 1'b0;
                tx_data  <= 8'h00;
            end else begin
                idx     <= idx + 3'd1;
                tx_data <= frame_byte(idx + 3'd1, snap, seq);
            end
        end
    end

    // The final byte is being accepted on this edge.
    assign done = tx_valid && tx_ready && (idx == LAST_IDX);

endmodule

// File: rtl/hit_readout_controller.sv
// Sequencer for the 24-channel hit latch bank: coincidence window, snapshot,
// frame readout and dead-time clear of the bank.
import hit_readout_pkg::*;

module hit_readout_controller #(
    parameter int N_CH            = 24,
    parameter int WINDOW_CYCLES   = 100,
    parameter int DEADTIME_CYCLES = 50,
    parameter int CNT_W           = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            arm,
    input  logic [N_CH-1:0] latch_q,
    output logic            latch_clr_n,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            busy,
    output logic [7:0]      seq,
    output logic [7:0]      pileup_count
);

    if (N_CH != 24) begin : g_bad_n_ch
        $error("hit_readout_controller: frame format requires N_CH == 24");
    end
    if (WINDOW_CYCLES < 1 || DEADTIME_CYCLES < 1) begin : g_bad_cycles
        $error("hit_readout_controller: window and dead time must be at least 1 cycle");
    end

    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [N_CH-1:0]  snapshot;
    logic             start;
    logic             frame_done;
    logic             clr_n_next;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state, serializer start and next value of the bank clear.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        clr_n_next = latch_clr_n;
        case (state)
            ST_IDLE: begin
                clr_n_next = arm;
                if (arm && (|latch_q)) state_next = ST_WINDOW;
            end
            ST_WINDOW: begin
                clr_n_next = 1'b1;
                if (cnt == WIN_LAST) begin
                    start      = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                clr_n_next = 1'b1;
                if (frame_done) begin
                    clr_n_next = 1'b0;
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr_n_next = 1'b0;
                if (cnt == DEAD_LAST) begin
                    clr_n_next = arm;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Shared window/dead-time counter, snapshot, sequence, pileup and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            snapshot     <= '0;
            seq          <= 8'h00;
            pileup_count <= 8'h00;
            latch_clr_n  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (state_next != state)
                cnt <= '0;
            else if (state == ST_WINDOW || state == ST_CLEAR)
                cnt <= cnt + CNT_W'(1);

            if (start) snapshot <= latch_q;

            if (frame_done) begin
                seq <= seq + 8'd1;
                if (((latch_q & ~snapshot) != '0) && (pileup_count != 8'hFF))
                    pileup_count <= pileup_count + 8'd1;
            end

            latch_clr_n <= clr_n_next;
            busy        <= (state_next != ST_IDLE);
        end
    end

    hit_frame_serializer u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .snap     (snapshot),
        .seq      (seq),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .done     (frame_done)
    );

endmodule

// File: tb/tb_hit_readout_controller.sv
// Randomized self-checking bench for hit_readout_controller with a frame-level reference model.
module tb_hit_readout_controller;

    localparam int W = 100;
    localparam int D = 50;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic [23:0] latch_q;
    logic        latch_clr_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  seq;
    logic [7:0]  pileup_count;

    int          n_checks;
    int          n_errors;
    logic [7:0]  exp_seq;
    logic [7:0]  exp_pile;

    hit_readout_controller #(
        .N_CH            (24),
        .WINDOW_CYCLES   (W),
        .DEADTIME_CYCLES (D),
        .CNT_W           (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .latch_q      (latch_q),
        .latch_clr_n  (latch_clr_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .seq          (seq),
        .pileup_count (pileup_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string where);
        check({where, "_clr_n"},  latch_clr_n,  0);
        check({where, "_valid"},  tx_valid,     0);
        check({where, "_data"},   tx_data,      0);
        check({where, "_busy"},   busy,         0);
        check({where, "_seq"},    seq,          0);
        check({where, "_pileup"}, pileup_count, 0);
    endtask

    // Wait (bounded) for an idle sequencer with the bank released.
    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(busy === 1'b0 && latch_clr_n === 1'b1) && guard < 500) begin
            tx_ready = 1'($urandom);
            @(negedge clk);
            guard++;
        end
        check("idle_wait_timeout", guard < 500, 1);
        check("idle_valid", tx_valid, 0);
    endtask

    // One event: first hit, a late hit inside the window, an optional hit after the
    // snapshot, optional stall on one byte, optional reset during byte rst_at.
    task automatic run_event(input logic [23:0] first, input logic [23:0] late,
                             input logic [23:0] post, input int late_off,
                             input int bp_idx, input int bp_len, input int rst_at);
        logic [23:0] snap;
        logic [7:0]  exp_bytes [5];
        int          i, stall, cyc;
        bit          rdy;

        wait_idle();
        latch_q   = first;
        snap      = first | late;
        exp_bytes = '{8'hA5, snap[7:0], snap[15:8], snap[23:16], exp_seq};

        @(negedge clk);
        check("busy_in_window", busy, 1);
        for (int t = 1; t < W; t++) begin
            if (t == late_off) latch_q = latch_q | late;
            tx_ready = 1'($urandom);
            @(negedge clk);
        end
        check("valid_before_window_end", tx_valid, 0);
        check("clr_n_in_window", latch_clr_n, 1);
        @(negedge clk);
        check("valid_at_window_end", tx_valid, 1);
        latch_q = latch_q | post;

        i = 0; stall = 0; cyc = 0;
        while (i < 5 && cyc < 100) begin
            check($sformatf("byte%0d_valid", i), tx_valid, 1);
            check($sformatf("byte%0d_data", i), tx_data, exp_bytes[i]);
            if (i == rst_at) begin
                tx_ready = 1'b0;
                rst_n    = 1'b0;
                #1;
                check_reset_values("async_reset");
                latch_q  = '0;
                exp_seq  = 8'h00;
                exp_pile = 8'h00;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            rdy = !(i == bp_idx && stall < bp_len);
            if (!rdy) stall++;
            tx_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) i++;
        end
        tx_ready = 1'b0;
        check("send_cycles", cyc, 5 + bp_len);

        exp_seq = exp_seq + 8'd1;
        if (((post & ~snap) != 24'h0) && exp_pile != 8'hFF) exp_pile = exp_pile + 8'd1;
        check("valid_after_frame", tx_valid, 0);
        check("seq_after_frame", seq, exp_seq);
        check("pileup_after_frame", pileup_count, exp_pile);

        cyc = 0;
        while (latch_clr_n === 1'b0 && cyc < 200) begin
            latch_q = '0;
            cyc++;
            @(negedge clk);
        end
        check("deadtime_len", cyc, D);
        check("busy_after_clear", busy, 0);
    endtask

    // Bound the whole run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus and checks.
    initial begin
        logic [23:0] first, late, post, cand;
        n_checks = 0;
        n_errors = 0;
        exp_seq  = 8'h00;
        exp_pile = 8'h00;
        rst_n    = 1'b0;
        arm      = 1'b0;
        latch_q  = '0;
        tx_ready = 1'b0;

        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Disarmed: hits are ignored and the bank stays cleared.
        latch_q = 24'h000055;
        for (int c = 0; c < 6; c++) begin
            tx_ready = 1'($urandom);
            @(negedge clk);
            check("disarmed_busy", busy, 0);
            check("disarmed_clr_n", latch_clr_n, 0);
            check("disarmed_valid", tx_valid, 0);
        end

        // Armed with no hits: bank released, still idle.
        arm     = 1'b1;
        latch_q = '0;
        repeat (10) @(negedge clk);
        check("armed_quiet_busy", busy, 0);
        check("armed_quiet_clr_n", latch_clr_n, 1);

        // Basic frame, backpressure on byte 2, and a single pileup bit.
        run_event(24'h000001, 24'h800000, 24'h0, $urandom_range(1, W - 1), -1, 0, -1);
        run_event(24'h000001, 24'h800000, 24'h0, $urandom_range(1, W - 1), 1, 7, -1);
        run_event(24'h000002, 24'h000000, 24'h000100, 1, -1, 0, -1);

        // Random events, every one with pileup: saturation and sequence wrap.
        for (int e = 0; e < 297; e++) begin
            first = 24'($urandom) & 24'h7FFFFF;
            if (first == 24'h0) first = 24'h000001;
            late  = 24'($urandom) & 24'h7FFFFF;
            cand  = ~(first | late) & 24'($urandom);
            post  = (cand == 24'h0) ? 24'h800000 : cand;
            run_event(first, late, post, $urandom_range(1, W - 1),
                      $urandom_range(0, 4), $urandom_range(0, 3), -1);
        end
        check("pileup_saturated", pileup_count, 8'hFF);

        // Reset during byte 3, then the next frame restarts at seq 0.
        run_event(24'h123456, 24'h0, 24'h0, 1, -1, 0, 2);
        run_event(24'h000010, 24'h000200, 24'h000100, 5, -1, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
